// File: rtl/shift_add_multiplier_if.sv
// Operand/result handshake bundle for the iterative shift-and-add multiplier.
// The master side is the upstream issue/writeback logic; the slave side is the multiplier.
interface shift_add_multiplier_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;
   logic        busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative 32x32 -> 64-bit unsigned shift-and-add multiplier.
// One partial-product accumulation per clock through a shared 32-bit adder.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high (unless rst)
// RUN   | 32 accumulate/shift steps, count tracks the step number
// DONE  | product presented with out_valid until out_ready

// 32-bit combinational adder without carry-out.
module adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);
   assign sum = a + b;
endmodule

module shift_add_multiplier #(
   parameter bit ZERO_BYPASS = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   shift_add_multiplier_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] m_q, m_d;
   logic [64:0] p_q, p_d;
   logic [4:0]  count_q, count_d;
   logic        out_valid_q, out_valid_d;
   logic [63:0] product_q, product_d;

   logic [31:0] sum;
   logic        carry;
   logic [64:0] p_step;
   logic        accept;

   adder u_adder (
      .a   (p_q[63:32]),
      .b   (m_q),
      .sum (sum)
   );

   // The adder has no carry-out, so recover it from the operand and sum MSBs.
   // Without an add the step is a plain logical right shift; bit 64 is zero after every step.
   always_comb begin
      carry  = (p_q[63] & m_q[31]) | ((p_q[63] ^ m_q[31]) & ~sum[31]);
      p_step = p_q[0] ? {1'b0, carry, sum, p_q[31:1]} : {1'b0, p_q[64:1]};
   end

   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.product   = product_q;
   assign accept        = bus.in_valid && bus.in_ready;

   // Next-state and datapath update for the IDLE/RUN/DONE sequence.
   always_comb begin
      state_d     = state_q;
      m_d         = m_q;
      p_d         = p_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      product_d   = product_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               m_d     = bus.a;
               p_d     = {33'b0, bus.b};
               count_d = 5'd0;
               if (ZERO_BYPASS && ((bus.a == 32'd0) || (bus.b == 32'd0))) begin
                  product_d   = 64'd0;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            p_d     = p_step;
            count_d = count_q + 5'd1;
            if (count_q == 5'd31) begin
               product_d   = p_step[63:0];
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         m_q         <= 32'd0;
         p_q         <= 65'd0;
         count_q     <= 5'd0;
         out_valid_q <= 1'b0;
         product_q   <= 64'd0;
      end else begin
         state_q     <= state_d;
         m_q         <= m_d;
         p_q         <= p_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         product_q   <= product_d;
      end
   end

endmodule
